// File: rtl/aes_trace_sequencer.sv
// Trace-campaign sequencer for AES_top power/VCD capture.
// Runs NUM_TRACES encryptions with enable hold, optional noise gap and ct capture.
module aes_trace_sequencer #(
  parameter int                DATA_W     = 128,
  parameter int                NUM_TRACES = 16,
  parameter int                EN_HOLD    = 51,
  parameter int                GAP_CYCLES = 15,
  parameter int                TIMEOUT    = 64,
  parameter logic [DATA_W-1:0] LFSR_SEED  = 1
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              gap_noise,
  input  logic [DATA_W-1:0] fixed_pt,
  input  logic [DATA_W-1:0] key,
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [DATA_W-1:0] AES_key_in,
  input  logic              AES_data_out_valid,
  input  logic [DATA_W-1:0] AES_data_out,
  output logic              ct_valid,
  output logic [DATA_W-1:0] ct_data,
  output logic [15:0]       trace_idx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       timeout_cnt
);

  localparam int RUN_LEN =
    (EN_HOLD > TIMEOUT) ? EN_HOLD : TIMEOUT;
  localparam logic [DATA_W-1:0] ONE = 1;
  localparam logic [DATA_W-1:0] SEED =
    (LFSR_SEED == '0) ? ONE : LFSR_SEED;
  localparam logic [DATA_W-1:0] TAPS = 'h87;
  localparam logic [15:0] RUN_END = 16'(RUN_LEN - 1);
  localparam logic [15:0] TO_END  = 16'(TIMEOUT - 1);
  localparam logic [15:0] EN_LEN  = 16'(EN_HOLD);
  localparam logic [15:0] GAP_END = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] LAST    = 16'(NUM_TRACES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, GAP, DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] pt_q;
  logic              mode_q;
  logic              noise_q;
  logic [15:0]       cyc;
  logic [15:0]       gap_cnt;
  logic              seen;

  logic              run_exit;
  logic              gap_end;
  logic              last;
  logic              cap;
  logic              noisy;
  logic [DATA_W-1:0] load_val;

  function automatic logic [DATA_W-1:0] lfsr_step(
    input logic [DATA_W-1:0] s
  );
    return {s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? TAPS : '0);
  endfunction

  assign run_exit = (cyc == RUN_END) && (seen || cyc >= TO_END);
  assign gap_end  = (gap_cnt == GAP_END);
  assign last     = (trace_idx == LAST);
  assign cap      = (state == RUN) && AES_data_out_valid && !seen;
  assign noisy    = (state == GAP) && noise_q;
  assign load_val = mode_q ? lfsr : pt_q;

  // Outputs decode from registered state only, so reset drops them at once.
  assign AES_en      = (state == RUN) && (cyc < EN_LEN);
  assign AES_data_in = (state == LOAD) ? load_val :
                       noisy           ? lfsr     : data_q;
  assign AES_key_in  = key_q;
  assign busy        = (state == LOAD) || (state == RUN) ||
                       (state == GAP);
  assign done        = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: state_nx = RUN;
      RUN:  if (run_exit) state_nx = GAP;
      GAP:  if (gap_end) state_nx = last ? DONE : LOAD;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state       <= IDLE;
      lfsr        <= SEED;
      data_q      <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      mode_q      <= 1'b0;
      noise_q     <= 1'b0;
      cyc         <= '0;
      gap_cnt     <= '0;
      seen        <= 1'b0;
      trace_idx   <= '0;
      timeout_cnt <= '0;
      ct_data     <= '0;
      ct_valid    <= 1'b0;
    end else begin
      state    <= state_nx;
      ct_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q      <= mode;
            noise_q     <= gap_noise;
            pt_q        <= fixed_pt;
            key_q       <= key;
            trace_idx   <= '0;
            timeout_cnt <= '0;
          end
        end
        LOAD: begin
          data_q <= load_val;
          lfsr   <= lfsr_step(lfsr);
          cyc    <= '0;
          seen   <= 1'b0;
        end
        RUN: begin
          cyc     <= cyc + 16'd1;
          gap_cnt <= '0;
          if (cap) begin
            ct_data  <= AES_data_out;
            ct_valid <= 1'b1;
            seen     <= 1'b1;
          end
          if (run_exit && !seen && !AES_data_out_valid &&
              timeout_cnt != 16'hFFFF)
            timeout_cnt <= timeout_cnt + 16'd1;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (noise_q) begin
            data_q <= lfsr;
            lfsr   <= lfsr_step(lfsr);
          end
          if (gap_end && !last)
            trace_idx <= trace_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
